// File: rtl/hilo_md_sequencer.sv
// hilo_md_sequencer
// Holds the architectural HI/LO registers and drives the external
// multi-cycle multiply/divide unit. Decode hands over one command at a
// time through a valid/ready handshake; MFHI/MFLO results go to the
// register-file write port. MFHI/MFLO wait behind an in-flight
// multiply/divide simply because the sequencer is not ready until the
// result has landed in HI/LO.

module hilo_md_sequencer #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_rs,
  input  logic [DATA_W-1:0] cmd_rt,
  input  logic [4:0]        cmd_rd,
  // multiply/divide unit
  output logic              md_start,
  output logic [1:0]        md_op,
  output logic [DATA_W-1:0] md_a,
  output logic [DATA_W-1:0] md_b,
  input  logic              md_done,
  input  logic [DATA_W-1:0] md_hi,
  input  logic [DATA_W-1:0] md_lo,
  // writeback side
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  // status
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q,
  output logic              busy,
  output logic              div_by_zero,
  output logic              md_timeout
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4;
  localparam logic [2:0] OP_MFLO  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  // The watchdog only needs to reach TIMEOUT-1.
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MD_START = 2'd1,
    MD_WAIT  = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] wd_cnt;

  logic accept;
  logic op_is_md;
  logic op_is_div;
  logic rt_zero;
  logic start_md;
  logic dbz_hit;
  logic mf_hit;
  logic wd_expire;
  logic md_finish;

  // Command decode. Acceptance is derived from the state directly rather
  // than from cmd_ready so the FSM block has no feedback through it.
  always_comb begin
    accept    = cmd_valid && (state == IDLE);
    op_is_md  = (cmd_op == OP_MULT) || (cmd_op == OP_MULTU) ||
                (cmd_op == OP_DIV)  || (cmd_op == OP_DIVU);
    op_is_div = (cmd_op == OP_DIV) || (cmd_op == OP_DIVU);
    rt_zero   = (cmd_rt == '0);
    start_md  = accept && op_is_md && !(op_is_div && rt_zero);
    dbz_hit   = accept && op_is_div && rt_zero;
    mf_hit    = accept && ((cmd_op == OP_MFHI) || (cmd_op == OP_MFLO));
    md_finish = (state == MD_WAIT) && md_done;
    // A done on the final watchdog cycle wins over the abort.
    wd_expire = (state == MD_WAIT) && !md_done && (wd_cnt == CNT_LAST);
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic and the state-decoded handshake/strobe outputs.
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    md_start   = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (start_md) next_state = MD_START;
      end
      MD_START: begin
        md_start   = 1'b1;
        next_state = MD_WAIT;
      end
      MD_WAIT: begin
        if (md_finish || wd_expire) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Watchdog: cleared while launching, counts every cycle spent waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == MD_START) begin
      wd_cnt <= '0;
    end else if (state == MD_WAIT) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  // Operand/opcode capture for the multiply/divide unit on launch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_a  <= '0;
      md_b  <= '0;
      md_op <= 2'b00;
    end else if (start_md) begin
      md_a  <= cmd_rs;
      md_b  <= cmd_rt;
      md_op <= cmd_op[1:0];
    end
  end

  // HI/LO update from a completed multiply/divide or from MTHI/MTLO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (md_finish) begin
      hi_q <= md_hi;
      lo_q <= md_lo;
    end else if (accept && (cmd_op == OP_MTHI)) begin
      hi_q <= cmd_rs;
    end else if (accept && (cmd_op == OP_MTLO)) begin
      lo_q <= cmd_rs;
    end
  end

  // MFHI/MFLO writeback; address/data hold when nothing is written and
  // a move to $zero is dropped entirely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= '0;
    end else begin
      wb_valid <= 1'b0;
      if (mf_hit && (cmd_rd != 5'd0)) begin
        wb_valid <= 1'b1;
        wb_rd    <= cmd_rd;
        wb_data  <= (cmd_op == OP_MFHI) ? hi_q : lo_q;
      end
    end
  end

  // Single-cycle error pulses, reported the cycle after the event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_by_zero <= 1'b0;
      md_timeout  <= 1'b0;
    end else begin
      div_by_zero <= dbz_hit;
      md_timeout  <= wd_expire;
    end
  end

endmodule
